// File: rtl/usb_pd_pkg.sv
// Shared USB-PD definitions: 4b5b K-codes, ioTRANSMIT type codes and the
// reset transmitter FSM encoding, plus the ordered-set symbol lookup.
package usb_pd_pkg;

    localparam int SYM_BITS    = 5;
    localparam int ORDSET_SYMS = 4;

    localparam logic [SYM_BITS-1:0] SYNC1 = 5'b11000;
    localparam logic [SYM_BITS-1:0] SYNC3 = 5'b00110;
    localparam logic [SYM_BITS-1:0] RST1  = 5'b00111;
    localparam logic [SYM_BITS-1:0] RST2  = 5'b11001;

    localparam logic [2:0] TX_HARD_RESET  = 3'b101;
    localparam logic [2:0] TX_CABLE_RESET = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_PREAMBLE,
        ST_ORDSET,
        ST_DONE,
        ST_FAIL
    } tx_state_t;

    // Hard Reset: RST-1 x3, RST-2.  Cable Reset: RST-1, Sync-1, RST-1, Sync-3.
    function automatic logic [SYM_BITS-1:0] ordset_sym(input logic [2:0] tx_type,
                                                       input logic [1:0] idx);
        logic [SYM_BITS-1:0] sym;
        if (tx_type == TX_CABLE_RESET) begin
            case (idx)
                2'd1:    sym = SYNC1;
                2'd3:    sym = SYNC3;
                default: sym = RST1;
            endcase
        end else begin
            sym = (idx == 2'd3) ? RST2 : RST1;
        end
        return sym;
    endfunction

endpackage

// File: rtl/pd_sym_serializer.sv
// Loads one 5-bit K-code and shifts it out LSB first under valid/ready,
// flagging the final bit of the symbol.
module pd_sym_serializer
    import usb_pd_pkg::*;
(
    input  logic                CLK,
    input  logic                reset,
    input  logic                load,
    input  logic [SYM_BITS-1:0] sym,
    input  logic                shift,
    output logic                bit_out,
    output logic                last
);

    logic [SYM_BITS-1:0] shreg;
    logic [2:0]          cnt;

    // NOTE: non-blocking assignments make every register update see the
    // pre-edge values, so statement order inside the block does not matter.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= sym;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= {1'b0, shreg[SYM_BITS-1:1]};
            cnt   <= cnt + 3'd1;
        end
    end

    assign bit_out = shreg[0];
    assign last    = (cnt == 3'(SYM_BITS - 1));

endmodule

// File: rtl/hard_reset_tx.sv
// TCPC Hard Reset / Cable Reset transmitter: waits for CC idle, then streams
// the alternating preamble and the reset ordered set to the BMC encoder.
module hard_reset_tx
    import usb_pd_pkg::*;
#(
    parameter int PREAMBLE_BITS = 64,
    parameter int IDLE_TIMEOUT  = 1000,
    parameter int TIMER_W       = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       tx_req,
    input  logic [2:0] tx_type,
    input  logic       cc_busy,
    input  logic       bit_ready,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       PHY_ACK,
    output logic       PHY_Stop_Attempting_Reset,
    output logic       tx_busy
);

    tx_state_t            state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]           type_q, type_d;
    logic [1:0]           idx_q, idx_d;

    logic                 accept;
    logic                 ser_load;
    logic                 ser_shift;
    logic                 ser_bit;
    logic                 ser_last;
    logic [SYM_BITS-1:0]  ser_sym;

    assign bit_valid = (state_q == ST_PREAMBLE) || (state_q == ST_ORDSET);
    assign accept    = bit_valid && bit_ready;
    assign ser_shift = accept && (state_q == ST_ORDSET);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            type_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        type_d   = type_q;
        idx_d    = idx_q;
        ser_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_req && (tx_type == TX_HARD_RESET || tx_type == TX_CABLE_RESET)) begin
                    type_d  = tx_type;
                    timer_d = '0;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!cc_busy) begin
                    timer_d = '0;
                    state_d = ST_PREAMBLE;
                end else if (timer_q == TIMER_W'(IDLE_TIMEOUT - 1)) begin
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            // The timer doubles as the preamble bit index; its LSB is the bit.
            ST_PREAMBLE: begin
                if (accept) begin
                    if (timer_q == TIMER_W'(PREAMBLE_BITS - 1)) begin
                        idx_d    = '0;
                        ser_load = 1'b1;
                        state_d  = ST_ORDSET;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            ST_ORDSET: begin
                if (accept && ser_last) begin
                    if (idx_q == 2'(ORDSET_SYMS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        ser_load = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ser_sym = ordset_sym(type_q, idx_d);
    end

    pd_sym_serializer u_ser (
        .CLK     (CLK),
        .reset   (reset),
        .load    (ser_load),
        .sym     (ser_sym),
        .shift   (ser_shift),
        .bit_out (ser_bit),
        .last    (ser_last)
    );

    assign bit_out = (state_q == ST_PREAMBLE) ? timer_q[0] :
                     (state_q == ST_ORDSET)   ? ser_bit    : 1'b0;
    assign PHY_ACK                   = (state_q == ST_DONE);
    assign PHY_Stop_Attempting_Reset = (state_q == ST_FAIL);
    assign tx_busy                   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hard_reset_tx.sv
// Self-checking bench for hard_reset_tx: vector table, randomized trials
// against a rule-level model, and hand-written timing/reset/ignore cases.
module tb_hard_reset_tx;

    localparam int PRE = 64;
    localparam int TMO = 1000;

    logic       CLK = 1'b0;
    logic       reset;
    logic       tx_req;
    logic [2:0] tx_type;
    logic       cc_busy;
    logic       bit_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       PHY_ACK;
    logic       PHY_Stop_Attempting_Reset;
    logic       tx_busy;

    always #5 CLK = ~CLK;

    hard_reset_tx #(
        .PREAMBLE_BITS (PRE),
        .IDLE_TIMEOUT  (TMO),
        .TIMER_W       (16)
    ) dut (
        .CLK                       (CLK),
        .reset                     (reset),
        .tx_req                    (tx_req),
        .tx_type                   (tx_type),
        .cc_busy                   (cc_busy),
        .bit_ready                 (bit_ready),
        .bit_out                   (bit_out),
        .bit_valid                 (bit_valid),
        .PHY_ACK                   (PHY_ACK),
        .PHY_Stop_Attempting_Reset (PHY_Stop_Attempting_Reset),
        .tx_busy                   (tx_busy)
    );

    typedef bit bitq_t[$];

    typedef struct {
        logic [2:0] t;
        int         busy;
        bit         rnd;
        bit         exp_ack;
        bit         exp_stop;
        string      name;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor state, sampled on the falling edge.
    int    cyc = 0;
    bitq_t got_q;
    int    ack_cnt, stop_cnt, both_total, stall_err, valid_runs, busy_seen;
    int    ack_cyc, stop_cyc, last_acc_cyc, idle_cyc, req_cyc;
    bit    busy_at_ack, prev_valid, stall_pend, stall_bit;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (stall_pend && !(bit_valid === 1'b1 && bit_out === stall_bit)) stall_err++;
        stall_pend = (bit_valid === 1'b1) && (bit_ready === 1'b0);
        stall_bit  = bit_out;
        if (bit_valid === 1'b1 && !prev_valid) valid_runs++;
        prev_valid = (bit_valid === 1'b1);
        if (tx_busy === 1'b1) busy_seen++;
        if (bit_valid === 1'b1 && bit_ready === 1'b1) begin
            got_q.push_back(bit_out);
            last_acc_cyc = cyc;
        end
        if (PHY_ACK === 1'b1) begin
            ack_cnt++;
            ack_cyc     = cyc;
            busy_at_ack = tx_busy;
        end
        if (PHY_Stop_Attempting_Reset === 1'b1) begin
            stop_cnt++;
            stop_cyc = cyc;
        end
        if (PHY_ACK === 1'b1 && PHY_Stop_Attempting_Reset === 1'b1) both_total++;
        if ((ack_cnt + stop_cnt) > 0 && tx_busy === 1'b0 && idle_cyc < 0) idle_cyc = cyc;
    end

    task automatic clear_mon();
        got_q.delete();
        ack_cnt = 0; stop_cnt = 0; stall_err = 0; valid_runs = 0; busy_seen = 0;
        ack_cyc = -1; stop_cyc = -1; last_acc_cyc = -1; idle_cyc = -1;
        busy_at_ack = 1'b0;
    endtask

    // cc_busy and bit_ready drivers, updated 2 time units after each edge.
    int busy_left  = 0;
    bit rand_ready = 1'b0;

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (busy_left > 0) begin
                cc_busy = 1'b1;
                busy_left--;
            end else begin
                cc_busy = 1'b0;
            end
            bit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model: the bit stream implied by the ordered-set rules.
    function automatic bitq_t model_stream(input logic [2:0] t);
        bitq_t      q;
        logic [4:0] k [4];
        if (t == 3'b101)      k = '{5'b00111, 5'b00111, 5'b00111, 5'b11001};
        else if (t == 3'b110) k = '{5'b00111, 5'b11000, 5'b00111, 5'b00110};
        else                  return q;
        for (int n = 0; n < PRE; n++) q.push_back(n % 2 == 1);
        for (int s = 0; s < 4; s++)
            for (int b = 0; b < 5; b++) q.push_back(k[s][b]);
        return q;
    endfunction

    function automatic bit type_ok(input logic [2:0] t);
        return (t == 3'b101) || (t == 3'b110);
    endfunction

    task automatic send_req(input logic [2:0] t, input int busy);
        @(posedge CLK); #1;
        tx_req    = 1'b1;
        tx_type   = t;
        busy_left = busy;
        req_cyc   = cyc;
        @(posedge CLK); #1;
        tx_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!((ack_cnt + stop_cnt) > 0 && tx_busy === 1'b0) && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        check({name, " finished in budget"}, 32'(n < budget), 32'd1);
        repeat (3) begin @(posedge CLK); #1; end
    endtask

    task automatic check_stream(input string name, input bitq_t exp);
        int mism = 0;
        check({name, " bit count"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            if (got_q[i] != exp[i]) mism++;
        check({name, " bit errors"}, mism, 0);
    endtask

    task automatic run_vec(input vec_t v);
        bitq_t exp_q;
        clear_mon();
        rand_ready = v.rnd;
        send_req(v.t, v.busy);
        if (v.exp_ack || v.exp_stop) wait_done(4000, v.name);
        else repeat (30) begin @(posedge CLK); #1; end
        exp_q = v.exp_ack ? model_stream(v.t) : exp_q;
        check({v.name, " ack count"}, ack_cnt, 32'(v.exp_ack));
        check({v.name, " stop count"}, stop_cnt, 32'(v.exp_stop));
        check_stream(v.name, exp_q);
        check({v.name, " stall stability"}, stall_err, 0);
        check({v.name, " valid runs"}, valid_runs, 32'(v.exp_ack));
        if (!(v.exp_ack || v.exp_stop)) check({v.name, " never busy"}, busy_seen, 0);
        check({v.name, " idle at end"}, 32'(tx_busy), 0);
        rand_ready = 1'b0;
        busy_left  = 0;
    endtask

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        int n;
        reset     = 1'b0;
        tx_req    = 1'b0;
        tx_type   = 3'b000;
        cc_busy   = 1'b0;
        bit_ready = 1'b1;
        clear_mon();
        prev_valid = 1'b0;
        stall_pend = 1'b0;
        both_total = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset bit_valid", 32'(bit_valid), 0);
        check("reset bit_out", 32'(bit_out), 0);
        check("reset ack", 32'(PHY_ACK), 0);
        check("reset stop", 32'(PHY_Stop_Attempting_Reset), 0);
        check("reset tx_busy", 32'(tx_busy), 0);
        reset = 1'b1;

        vecs[0] = '{3'b101, 0,       1'b0, 1'b1, 1'b0, "hard"};
        vecs[1] = '{3'b110, 0,       1'b0, 1'b1, 1'b0, "cable"};
        vecs[2] = '{3'b101, 0,       1'b1, 1'b1, 1'b0, "hard_stall"};
        vecs[3] = '{3'b110, 0,       1'b1, 1'b1, 1'b0, "cable_stall"};
        vecs[4] = '{3'b101, 500,     1'b0, 1'b1, 1'b0, "busy500"};
        vecs[5] = '{3'b110, TMO,     1'b0, 1'b1, 1'b0, "busy_edge"};
        vecs[6] = '{3'b101, TMO + 1, 1'b0, 1'b0, 1'b1, "busy_timeout"};
        vecs[7] = '{3'b000, 0,       1'b0, 1'b0, 1'b0, "type000"};
        vecs[8] = '{3'b111, 0,       1'b0, 1'b0, 1'b0, "type111"};
        vecs[9] = '{3'b100, 0,       1'b0, 1'b0, 1'b0, "type100"};
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Randomized trials; expectations come from the request/timeout rules.
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            case ($urandom_range(0, 4))
                0:       v.t = 3'b101;
                1:       v.t = 3'b110;
                2:       v.t = 3'b101;
                3:       v.t = 3'b110;
                default: v.t = 3'($urandom);
            endcase
            v.busy     = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 2, TMO + 2)
                                                     : $urandom_range(0, 40);
            v.rnd      = 1'($urandom_range(0, 1));
            v.exp_ack  = type_ok(v.t) && (v.busy <= TMO);
            v.exp_stop = type_ok(v.t) && (v.busy > TMO);
            v.name     = $sformatf("rand%0d", i);
            run_vec(v);
        end

        // First-bit latency and ack / idle timing.
        clear_mon();
        send_req(3'b101, 0);
        check("lat tx_busy at t+1", 32'(tx_busy), 1);
        check("lat no valid at t+1", 32'(bit_valid), 0);
        @(posedge CLK); #1;
        check("lat valid at t+2", 32'(bit_valid), 1);
        check("lat first bit", 32'(bit_out), 0);
        wait_done(500, "timing");
        check("ack one after last bit", ack_cyc, last_acc_cyc + 1);
        check("idle one after ack", idle_cyc, ack_cyc + 1);
        check("busy during ack", 32'(busy_at_ack), 1);
        check_stream("timing", model_stream(3'b101));

        // Idle-wait timeout: stop exactly TMO cycles after entering WAIT_IDLE.
        clear_mon();
        send_req(3'b110, 3 * TMO);
        wait_done(3000, "timeout");
        check("timeout stop cycle", stop_cyc, req_cyc + 1 + TMO);
        check("timeout stop count", stop_cnt, 1);
        check("timeout no ack", ack_cnt, 0);
        check("timeout no valid", valid_runs, 0);
        busy_left = 0;
        repeat (2) @(posedge CLK);

        // Reset while preamble bit 30 is on the line.
        clear_mon();
        send_req(3'b101, 0);
        n = 0;
        while (got_q.size() < 30 && n < 500) begin @(posedge CLK); #1; n++; end
        check("reached bit 30", got_q.size(), 30);
        check("bit 30 value", 32'(bit_out), 0);
        reset = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b1;
        check("midreset bit_valid", 32'(bit_valid), 0);
        check("midreset tx_busy", 32'(tx_busy), 0);
        check("midreset ack", 32'(PHY_ACK), 0);
        check("midreset stop", 32'(PHY_Stop_Attempting_Reset), 0);
        repeat (20) begin @(posedge CLK); #1; end
        check("midreset no ack later", ack_cnt, 0);
        check("midreset no stop later", stop_cnt, 0);
        clear_mon();
        send_req(3'b101, 0);
        wait_done(500, "after reset");
        check("after reset ack", ack_cnt, 1);
        check_stream("after reset", model_stream(3'b101));

        // Request during preamble must be ignored.
        clear_mon();
        send_req(3'b101, 0);
        repeat (10) begin @(posedge CLK); #1; end
        tx_req  = 1'b1;
        tx_type = 3'b110;
        @(posedge CLK); #1;
        tx_req = 1'b0;
        wait_done(500, "ignore req");
        repeat (20) begin @(posedge CLK); #1; end
        check("ignore req ack count", ack_cnt, 1);
        check("ignore req valid runs", valid_runs, 1);
        check_stream("ignore req", model_stream(3'b101));

        check("ack and stop never together", both_total, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
